// File: rtl/pattern_seq_decoder.sv
// Receive-side decoder for the 7-step 6-bit sliding-light code: maps code words to
// step indices, tracks the 0..6 step order, locks on a run of in-order steps.
module pattern_seq_decoder #(
   parameter int unsigned LOCK_CNT  = 3,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [5:0]           code_in,
   input  logic                 code_vld,
   input  logic                 clr_err,
   output logic [2:0]           q_out,
   output logic                 q_vld,
   output logic                 code_err,
   output logic                 seq_err,
   output logic                 locked,
   output logic [ERR_CNT_W-1:0] err_count
);

   typedef enum logic [0:0] {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam logic [2:0]           LOCK_RUN = 3'(LOCK_CNT);
   localparam logic [ERR_CNT_W-1:0] CNT_MAX  = {ERR_CNT_W{1'b1}};
   localparam logic [ERR_CNT_W-1:0] CNT_ONE  = ERR_CNT_W'(1);

   // Exact-match lookup; bit 3 is the legal flag, bits 2:0 the step index.
   function automatic logic [3:0] decode_code(input logic [5:0] code);
      logic [3:0] res;
      case (code)
         6'b100000: res = {1'b1, 3'd0};
         6'b110000: res = {1'b1, 3'd1};
         6'b111000: res = {1'b1, 3'd2};
         6'b011100: res = {1'b1, 3'd3};
         6'b001110: res = {1'b1, 3'd4};
         6'b000111: res = {1'b1, 3'd5};
         6'b000011: res = {1'b1, 3'd6};
         default:   res = {1'b0, 3'd0};
      endcase
      return res;
   endfunction

   state_t                 state_r;
   state_t                 state_nx_s;
   logic [2:0]             run_r;
   logic [2:0]             run_nx_s;
   logic [2:0]             last_r;
   logic [2:0]             last_nx_s;
   logic [2:0]             q_out_nx_s;
   logic                   q_vld_nx_s;
   logic                   code_err_nx_s;
   logic                   seq_err_nx_s;
   logic [ERR_CNT_W-1:0]   err_count_nx_s;

   logic [3:0]             dec_s;
   logic                   legal_s;
   logic [2:0]             idx_s;
   logic [2:0]             expected_s;
   logic                   in_order_s;
   logic [2:0]             hunt_run_s;

   assign dec_s      = decode_code(code_in);
   assign legal_s    = dec_s[3];
   assign idx_s      = dec_s[2:0];
   assign expected_s = (last_r == 3'd6) ? 3'd0 : (last_r + 3'd1);
   assign in_order_s = legal_s && (idx_s == expected_s);

   // A run only grows from a non-empty run; any other legal word reseeds it at 1.
   assign hunt_run_s = !legal_s ? 3'd0 :
                       ((run_r != 3'd0) && (idx_s == expected_s)) ? (run_r + 3'd1) : 3'd1;

   // Next-state, run tracking and output pulses for the sampled word.
   always_comb begin
      state_nx_s    = state_r;
      run_nx_s      = run_r;
      last_nx_s     = last_r;
      q_out_nx_s    = q_out;
      q_vld_nx_s    = 1'b0;
      code_err_nx_s = 1'b0;
      seq_err_nx_s  = 1'b0;
      if (code_vld) begin
         if (legal_s) begin
            q_out_nx_s = idx_s;
            q_vld_nx_s = 1'b1;
            last_nx_s  = idx_s;
         end else begin
            code_err_nx_s = 1'b1;
         end
         case (state_r)
            HUNT: begin
               run_nx_s = hunt_run_s;
               if (hunt_run_s == LOCK_RUN) begin
                  state_nx_s = LOCKED;
               end else begin
                  state_nx_s = HUNT;
               end
            end
            LOCKED: begin
               if (in_order_s) begin
                  state_nx_s = LOCKED;
               end else begin
                  seq_err_nx_s = 1'b1;
                  state_nx_s   = HUNT;
                  run_nx_s     = legal_s ? 3'd1 : 3'd0;
               end
            end
            default: begin
               state_nx_s = HUNT;
               run_nx_s   = 3'd0;
            end
         endcase
      end else begin
         state_nx_s = state_r;
         run_nx_s   = run_r;
      end
   end

   // Saturating error counter; a clear drops any same-cycle increment.
   always_comb begin
      err_count_nx_s = err_count;
      if (clr_err) begin
         err_count_nx_s = '0;
      end else if (seq_err_nx_s && (err_count != CNT_MAX)) begin
         err_count_nx_s = err_count + CNT_ONE;
      end else begin
         err_count_nx_s = err_count;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= HUNT;
         run_r     <= 3'd0;
         last_r    <= 3'd0;
         q_out     <= 3'd0;
         q_vld     <= 1'b0;
         code_err  <= 1'b0;
         seq_err   <= 1'b0;
         locked    <= 1'b0;
         err_count <= '0;
      end else begin
         state_r   <= state_nx_s;
         run_r     <= run_nx_s;
         last_r    <= last_nx_s;
         q_out     <= q_out_nx_s;
         q_vld     <= q_vld_nx_s;
         code_err  <= code_err_nx_s;
         seq_err   <= seq_err_nx_s;
         locked    <= (state_nx_s == LOCKED);
         err_count <= err_count_nx_s;
      end
   end

endmodule
